// File: rtl/axis_bram_datamover_responder.sv
// DataMover-style command responder: S2MM stream -> BRAM port A,
// MM2S BRAM port B -> stream, each direction with its own command/status FSM.
module axis_bram_datamover_responder #(
  parameter int C_ADDR_WIDTH = 13,
  parameter int C_BTT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [71:0]             s_axis_s2mm_cmd_tdata,
  input  logic                    s_axis_s2mm_cmd_tvalid,
  output logic                    s_axis_s2mm_cmd_tready,
  output logic [31:0]             m_axis_s2mm_sts_tdata,
  output logic                    m_axis_s2mm_sts_tvalid,
  input  logic                    m_axis_s2mm_sts_tready,
  input  logic [7:0]              s_axis_s2mm_tdata,
  input  logic                    s_axis_s2mm_tvalid,
  output logic                    s_axis_s2mm_tready,
  input  logic                    s_axis_s2mm_tlast,
  input  logic [71:0]             s_axis_mm2s_cmd_tdata,
  input  logic                    s_axis_mm2s_cmd_tvalid,
  output logic                    s_axis_mm2s_cmd_tready,
  output logic [7:0]              m_axis_mm2s_sts_tdata,
  output logic                    m_axis_mm2s_sts_tvalid,
  input  logic                    m_axis_mm2s_sts_tready,
  output logic [7:0]              m_axis_mm2s_tdata,
  output logic                    m_axis_mm2s_tvalid,
  input  logic                    m_axis_mm2s_tready,
  output logic                    m_axis_mm2s_tlast,
  output logic [C_ADDR_WIDTH-1:0] bram_a_addr,
  output logic [7:0]              bram_a_din,
  output logic                    bram_a_we,
  output logic [C_ADDR_WIDTH-1:0] bram_b_addr,
  output logic                    bram_b_en,
  input  logic [7:0]              bram_b_dout
);

  localparam int CW = C_BTT_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_DRAIN, S_STS} s_state_t;
  typedef enum logic [1:0] {M_IDLE, M_DATA, M_STS} m_state_t;

  // Command decode: range check is done wide so it can never wrap.
  logic [C_BTT_WIDTH-1:0] w_s_btt;
  logic [C_BTT_WIDTH-1:0] w_m_btt;
  logic [32:0]            w_s_end;
  logic [32:0]            w_m_end;
  logic                   w_s_err;
  logic                   w_m_err;
  logic                   w_unused;

  assign w_s_btt = s_axis_s2mm_cmd_tdata[C_BTT_WIDTH-1:0];
  assign w_m_btt = s_axis_mm2s_cmd_tdata[C_BTT_WIDTH-1:0];
  assign w_s_end = {1'b0, s_axis_s2mm_cmd_tdata[63:32]}
                 + 33'(w_s_btt) - 33'd1;
  assign w_m_end = {1'b0, s_axis_mm2s_cmd_tdata[63:32]}
                 + 33'(w_m_btt) - 33'd1;
  assign w_s_err = (w_s_btt == '0)
                 | (|s_axis_s2mm_cmd_tdata[22:C_BTT_WIDTH])
                 | ~s_axis_s2mm_cmd_tdata[23]
                 | (|w_s_end[32:C_ADDR_WIDTH]);
  assign w_m_err = (w_m_btt == '0)
                 | (|s_axis_mm2s_cmd_tdata[22:C_BTT_WIDTH])
                 | ~s_axis_mm2s_cmd_tdata[23]
                 | (|w_m_end[32:C_ADDR_WIDTH]);
  assign w_unused = ^{s_axis_s2mm_cmd_tdata[71:68],
                      s_axis_s2mm_cmd_tdata[31:24],
                      s_axis_mm2s_cmd_tdata[71:68],
                      s_axis_mm2s_cmd_tdata[31],
                      s_axis_mm2s_cmd_tdata[29:24],
                      w_s_end[C_ADDR_WIDTH-1:0],
                      w_m_end[C_ADDR_WIDTH-1:0]};

  // ---------------- S2MM ----------------
  s_state_t               r_s_state;
  s_state_t               w_s_nxt;
  logic [C_ADDR_WIDTH-1:0] r_s_waddr;
  logic [CW-1:0]          r_s_cnt;
  logic [CW-1:0]          r_s_btt;
  logic [3:0]             r_s_tag;
  logic [31:0]            r_s_sts;
  logic [CW-1:0]          w_s_cnt1;
  logic                   w_s_cmd_rdy;
  logic                   w_s_rdy;
  logic                   w_s_we;

  assign w_s_cnt1 = r_s_cnt + CW'(1);

  always_comb begin
    w_s_nxt     = r_s_state;
    w_s_cmd_rdy = 1'b0;
    w_s_rdy     = 1'b0;
    w_s_we      = 1'b0;
    unique case (r_s_state)
      S_IDLE: begin
        w_s_cmd_rdy = resetn;
        if (resetn && s_axis_s2mm_cmd_tvalid)
          w_s_nxt = w_s_err ? S_STS : S_DATA;
      end
      S_DATA: begin
        w_s_rdy = resetn;
        w_s_we  = resetn & s_axis_s2mm_tvalid;
        if (w_s_we) begin
          if (s_axis_s2mm_tlast)
            w_s_nxt = S_STS;
          else if (w_s_cnt1 == r_s_btt)
            w_s_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_s_rdy = resetn;
        if (resetn && s_axis_s2mm_tvalid && s_axis_s2mm_tlast)
          w_s_nxt = S_STS;
      end
      S_STS: begin
        if (m_axis_s2mm_sts_tready)
          w_s_nxt = S_IDLE;
      end
      default: w_s_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_s_state <= S_IDLE;
    else         r_s_state <= w_s_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_s_waddr <= '0;
      r_s_cnt   <= '0;
      r_s_btt   <= '0;
      r_s_tag   <= '0;
      r_s_sts   <= '0;
    end else begin
      if (r_s_state == S_IDLE && s_axis_s2mm_cmd_tvalid) begin
        r_s_waddr <= s_axis_s2mm_cmd_tdata[32 +: C_ADDR_WIDTH];
        r_s_cnt   <= '0;
        r_s_btt   <= CW'(w_s_btt);
        r_s_tag   <= s_axis_s2mm_cmd_tdata[67:64];
        if (w_s_err)
          r_s_sts <= {1'b0, 23'd0, 4'b0010,
                      s_axis_s2mm_cmd_tdata[67:64]};
      end
      if (w_s_we) begin
        r_s_waddr <= r_s_waddr + C_ADDR_WIDTH'(1);
        r_s_cnt   <= w_s_cnt1;
        if (s_axis_s2mm_tlast)
          r_s_sts <= {1'b1, 23'(w_s_cnt1), 4'b1000, r_s_tag};
      end
      // Overlong frame: bytes past BTT were dropped
      if (r_s_state == S_DRAIN && s_axis_s2mm_tvalid
          && s_axis_s2mm_tlast)
        r_s_sts <= {1'b1, 23'(r_s_btt), 4'b0001, r_s_tag};
    end
  end

  assign s_axis_s2mm_cmd_tready = w_s_cmd_rdy;
  assign s_axis_s2mm_tready     = w_s_rdy;
  assign m_axis_s2mm_sts_tvalid = (r_s_state == S_STS);
  assign m_axis_s2mm_sts_tdata  = r_s_sts;
  assign bram_a_addr            = r_s_waddr;
  assign bram_a_din             = s_axis_s2mm_tdata;
  assign bram_a_we              = w_s_we;

  // ---------------- MM2S ----------------
  m_state_t               r_m_state;
  m_state_t               w_m_nxt;
  logic [C_ADDR_WIDTH-1:0] r_m_raddr;
  logic [CW-1:0]          r_m_rcnt;
  logic [CW-1:0]          r_m_ocnt;
  logic [CW-1:0]          r_m_btt;
  logic [3:0]             r_m_tag;
  logic                   r_m_eof;
  logic [7:0]             r_m_sts;
  logic                   r_m_pend;
  logic [1:0]             r_m_occ;
  logic [7:0]             r_m_b0;
  logic [7:0]             r_m_b1;
  logic                   w_m_vld;
  logic                   w_m_pop;
  logic [1:0]             w_m_occ_nx;
  logic [CW-1:0]          w_m_ocnt1;
  logic                   w_m_fin;
  logic                   w_m_cmd_rdy;
  logic                   w_m_en;
  logic [C_ADDR_WIDTH-1:0] w_m_addr;

  assign w_m_vld    = (r_m_occ != 2'd0);
  assign w_m_pop    = w_m_vld & m_axis_mm2s_tready;
  assign w_m_occ_nx = r_m_occ + {1'b0, r_m_pend}
                    - {1'b0, w_m_pop};
  assign w_m_ocnt1  = r_m_ocnt + CW'(1);
  assign w_m_fin    = w_m_pop & (w_m_ocnt1 == r_m_btt);

  // A read is launched only if its byte will find a free skid slot.
  always_comb begin
    w_m_nxt     = r_m_state;
    w_m_cmd_rdy = 1'b0;
    w_m_en      = 1'b0;
    w_m_addr    = r_m_raddr;
    unique case (r_m_state)
      M_IDLE: begin
        w_m_cmd_rdy = resetn;
        w_m_addr    = s_axis_mm2s_cmd_tdata[32 +: C_ADDR_WIDTH];
        if (resetn && s_axis_mm2s_cmd_tvalid) begin
          if (w_m_err) begin
            w_m_nxt = M_STS;
          end else begin
            w_m_nxt = M_DATA;
            w_m_en  = 1'b1;
          end
        end
      end
      M_DATA: begin
        w_m_en = resetn & (r_m_rcnt != r_m_btt)
               & (w_m_occ_nx < 2'd2);
        if (w_m_fin)
          w_m_nxt = M_STS;
      end
      M_STS: begin
        if (m_axis_mm2s_sts_tready)
          w_m_nxt = M_IDLE;
      end
      default: w_m_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_m_state <= M_IDLE;
    else         r_m_state <= w_m_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_m_raddr <= '0;
      r_m_rcnt  <= '0;
      r_m_ocnt  <= '0;
      r_m_btt   <= '0;
      r_m_tag   <= '0;
      r_m_eof   <= 1'b0;
      r_m_sts   <= '0;
      r_m_pend  <= 1'b0;
      r_m_occ   <= '0;
      r_m_b0    <= '0;
      r_m_b1    <= '0;
    end else begin
      r_m_pend <= w_m_en;
      r_m_occ  <= w_m_occ_nx;
      unique case ({r_m_pend, w_m_pop})
        2'b10: begin
          if (r_m_occ == 2'd0) r_m_b0 <= bram_b_dout;
          else                 r_m_b1 <= bram_b_dout;
        end
        2'b01: r_m_b0 <= r_m_b1;
        2'b11: begin
          if (r_m_occ == 2'd1) begin
            r_m_b0 <= bram_b_dout;
          end else begin
            r_m_b0 <= r_m_b1;
            r_m_b1 <= bram_b_dout;
          end
        end
        default: ;
      endcase
      if (r_m_state == M_IDLE && s_axis_mm2s_cmd_tvalid) begin
        r_m_btt   <= CW'(w_m_btt);
        r_m_tag   <= s_axis_mm2s_cmd_tdata[67:64];
        r_m_eof   <= s_axis_mm2s_cmd_tdata[30];
        r_m_ocnt  <= '0;
        r_m_rcnt  <= CW'(1);
        r_m_raddr <= w_m_addr + C_ADDR_WIDTH'(1);
        if (w_m_err)
          r_m_sts <= {4'b0010, s_axis_mm2s_cmd_tdata[67:64]};
      end
      if (r_m_state == M_DATA) begin
        if (w_m_en) begin
          r_m_rcnt  <= r_m_rcnt + CW'(1);
          r_m_raddr <= r_m_raddr + C_ADDR_WIDTH'(1);
        end
        if (w_m_pop) r_m_ocnt <= w_m_ocnt1;
        if (w_m_fin) r_m_sts  <= {4'b1000, r_m_tag};
      end
    end
  end

  assign s_axis_mm2s_cmd_tready = w_m_cmd_rdy;
  assign m_axis_mm2s_sts_tvalid = (r_m_state == M_STS);
  assign m_axis_mm2s_sts_tdata  = r_m_sts;
  assign m_axis_mm2s_tvalid     = w_m_vld;
  assign m_axis_mm2s_tdata      = r_m_b0;
  assign m_axis_mm2s_tlast      = r_m_eof & w_m_vld
                                & (w_m_ocnt1 == r_m_btt);
  assign bram_b_addr            = w_m_addr;
  assign bram_b_en              = w_m_en;

endmodule
